// File: rtl/ps2_kbd_sequencer.sv
// PS/2 keyboard protocol controller: scan-code decoder for game keys plus the
// Set-LEDs command sequencer, sharing one receive byte stream.
module ps2_kbd_sequencer #(
  parameter int ACK_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       led_busy,
  output logic       led_done,
  output logic       led_fail,
  output logic [3:0] wasd,
  output logic [3:0] arrows,
  output logic       space,
  output logic       enter,
  output logic       key_event,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       proto_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [7:0] B_E0  = 8'hE0;
  localparam logic [7:0] B_F0  = 8'hF0;
  localparam logic [7:0] B_ACK = 8'hFA;
  localparam logic [7:0] B_RES = 8'hFE;
  localparam logic [7:0] B_SET = 8'hED;

  typedef enum logic [1:0] {D_IDLE, D_E0, D_F0, D_E0F0} dec_state_t;
  typedef enum logic [2:0] {
    C_IDLE, C_SEND1, C_WAIT_TX1, C_WAIT_ACK1, C_SEND2, C_WAIT_TX2, C_WAIT_ACK2
  } cmd_state_t;

  dec_state_t dec_q, dec_d;
  cmd_state_t cmd_q, cmd_d;

  logic [3:0]    wasd_q, wasd_d, arrows_q, arrows_d;
  logic          space_q, space_d, enter_q, enter_d;
  logic          key_event_q, key_event_d, key_ext_q, key_ext_d;
  logic          key_break_q, key_break_d, proto_err_q, proto_err_d;
  logic [7:0]    key_code_q, key_code_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_send_q, tx_send_d;
  logic          led_busy_q, led_busy_d, led_done_q, led_done_d;
  logic          led_fail_q, led_fail_d;
  logic [2:0]    led_arg_q, led_arg_d, pend_val_q, pend_val_d;
  logic          pend_valid_q, pend_valid_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          seen_busy_q, seen_busy_d;

  logic cmd_rx, dec_rx, is_ext, is_brk, held;

  // ACK/resend bytes belong to the command FSM only while it is waiting for one.
  always_comb begin
    cmd_rx = rx_valid && (cmd_q == C_WAIT_ACK1 || cmd_q == C_WAIT_ACK2) &&
             (rx_data == B_ACK || rx_data == B_RES);
    dec_rx = rx_valid && !cmd_rx;
  end

  always_comb begin
    dec_d       = dec_q;
    wasd_d      = wasd_q;
    arrows_d    = arrows_q;
    space_d     = space_q;
    enter_d     = enter_q;
    key_event_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    proto_err_d = 1'b0;
    is_ext      = (dec_q == D_E0) || (dec_q == D_E0F0);
    is_brk      = (dec_q == D_F0) || (dec_q == D_E0F0);
    held        = !is_brk;

    if (dec_rx) begin
      if (rx_data == 8'h00 || rx_data == 8'hFF) begin
        proto_err_d = 1'b1;
        dec_d       = D_IDLE;
      end else if (rx_data == B_E0) begin
        if (dec_q == D_F0 || dec_q == D_E0F0) proto_err_d = 1'b1;
        dec_d = D_E0;
      end else if (rx_data == B_F0) begin
        if (dec_q == D_IDLE)     dec_d = D_F0;
        else if (dec_q == D_E0)  dec_d = D_E0F0;
      end else if (dec_q == D_IDLE && (rx_data == 8'hAA || rx_data == 8'hEE ||
                                       rx_data == B_ACK || rx_data == B_RES)) begin
        dec_d = D_IDLE;
      end else begin
        dec_d       = D_IDLE;
        key_event_d = 1'b1;
        key_code_d  = rx_data;
        key_ext_d   = is_ext;
        key_break_d = is_brk;
        if (is_ext) begin
          case (rx_data)
            8'h75:   arrows_d[0] = held;
            8'h6B:   arrows_d[1] = held;
            8'h72:   arrows_d[2] = held;
            8'h74:   arrows_d[3] = held;
            default: ;
          endcase
        end else begin
          case (rx_data)
            8'h1D:   wasd_d[0] = held;
            8'h1C:   wasd_d[1] = held;
            8'h1B:   wasd_d[2] = held;
            8'h23:   wasd_d[3] = held;
            8'h29:   space_d   = held;
            8'h5A:   enter_d   = held;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    cmd_d        = cmd_q;
    tx_data_d    = tx_data_q;
    tx_send_d    = 1'b0;
    led_done_d   = 1'b0;
    led_fail_d   = 1'b0;
    led_arg_d    = led_arg_q;
    pend_valid_d = pend_valid_q;
    pend_val_d   = pend_val_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    seen_busy_d  = seen_busy_q;

    // Requests arriving mid-command (including the completion cycle) queue here.
    if (led_req && cmd_q != C_IDLE) begin
      pend_valid_d = 1'b1;
      pend_val_d   = led_val;
    end

    case (cmd_q)
      C_IDLE: begin
        if (led_req || pend_valid_q) begin
          led_arg_d    = led_req ? led_val : pend_val_q;
          pend_valid_d = 1'b0;
          retry_d      = '0;
          cmd_d        = C_SEND1;
        end
      end
      C_SEND1, C_SEND2: begin
        tx_data_d   = (cmd_q == C_SEND1) ? B_SET : {5'b0, led_arg_q};
        tx_send_d   = 1'b1;
        timer_d     = '0;
        seen_busy_d = 1'b0;
        cmd_d       = (cmd_q == C_SEND1) ? C_WAIT_TX1 : C_WAIT_TX2;
      end
      C_WAIT_TX1, C_WAIT_TX2: begin
        timer_d = timer_q + TW'(1);
        if (tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          timer_d = '0;
          cmd_d   = (cmd_q == C_WAIT_TX1) ? C_WAIT_ACK1 : C_WAIT_ACK2;
        end else if (timer_q == TMO_LAST) begin
          led_fail_d = 1'b1;
          cmd_d      = C_IDLE;
        end
      end
      C_WAIT_ACK1, C_WAIT_ACK2: begin
        timer_d = timer_q + TW'(1);
        if (cmd_rx && rx_data == B_ACK) begin
          retry_d = '0;
          if (cmd_q == C_WAIT_ACK1) begin
            cmd_d = C_SEND2;
          end else begin
            led_done_d = 1'b1;
            cmd_d      = C_IDLE;
          end
        end else if (cmd_rx) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            cmd_d   = (cmd_q == C_WAIT_ACK1) ? C_SEND1 : C_SEND2;
          end else begin
            led_fail_d = 1'b1;
            cmd_d      = C_IDLE;
          end
        end else if (timer_q == TMO_LAST) begin
          led_fail_d = 1'b1;
          cmd_d      = C_IDLE;
        end
      end
      default: cmd_d = C_IDLE;
    endcase

    led_busy_d = (cmd_d != C_IDLE);
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      dec_q        <= D_IDLE;
      cmd_q        <= C_IDLE;
      wasd_q       <= '0;
      arrows_q     <= '0;
      space_q      <= 1'b0;
      enter_q      <= 1'b0;
      key_event_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      proto_err_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_send_q    <= 1'b0;
      led_busy_q   <= 1'b0;
      led_done_q   <= 1'b0;
      led_fail_q   <= 1'b0;
      led_arg_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      retry_q      <= '0;
      timer_q      <= '0;
      seen_busy_q  <= 1'b0;
    end else begin
      dec_q        <= dec_d;
      cmd_q        <= cmd_d;
      wasd_q       <= wasd_d;
      arrows_q     <= arrows_d;
      space_q      <= space_d;
      enter_q      <= enter_d;
      key_event_q  <= key_event_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      proto_err_q  <= proto_err_d;
      tx_data_q    <= tx_data_d;
      tx_send_q    <= tx_send_d;
      led_busy_q   <= led_busy_d;
      led_done_q   <= led_done_d;
      led_fail_q   <= led_fail_d;
      led_arg_q    <= led_arg_d;
      pend_valid_q <= pend_valid_d;
      pend_val_q   <= pend_val_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      seen_busy_q  <= seen_busy_d;
    end
  end

  assign wasd      = wasd_q;
  assign arrows    = arrows_q;
  assign space     = space_q;
  assign enter     = enter_q;
  assign key_event = key_event_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign proto_err = proto_err_q;
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign led_busy  = led_busy_q;
  assign led_done  = led_done_q;
  assign led_fail  = led_fail_q;

endmodule

// File: tb/tb_ps2_kbd_sequencer.sv
// Directed testbench for ps2_kbd_sequencer: key decoding, LED command
// sequencing with ACK/resend/timeout, byte routing and mid-command reset.
module tb_ps2_kbd_sequencer;

   localparam int ACK_TO = 40;

   logic       clock;
   logic       resetN;
   logic [7:0] rxData;
   logic       rxValid;
   logic [7:0] txData;
   logic       txSend;
   logic       txBusy;
   logic       ledReq;
   logic [2:0] ledVal;
   logic       ledBusy, ledDone, ledFail;
   logic [3:0] wasd, arrows;
   logic       space, enter, keyEvent, keyExt, keyBreak, protoErr;
   logic [7:0] keyCode;

   int totalChecks = 0;
   int badChecks   = 0;
   int doneCount   = 0;
   int failCount   = 0;
   logic [7:0] txLog[$];

   ps2_kbd_sequencer #(.ACK_TIMEOUT(ACK_TO), .MAX_RETRY(3)) dut (
      .CLOCK(clock), .reset(resetN),
      .rx_data(rxData), .rx_valid(rxValid),
      .tx_data(txData), .tx_send(txSend), .tx_busy(txBusy),
      .led_req(ledReq), .led_val(ledVal),
      .led_busy(ledBusy), .led_done(ledDone), .led_fail(ledFail),
      .wasd(wasd), .arrows(arrows), .space(space), .enter(enter),
      .key_event(keyEvent), .key_code(keyCode), .key_ext(keyExt),
      .key_break(keyBreak), .proto_err(protoErr)
   );

   // Free-running 100 MHz-style clock; only the rising edge matters to the DUT.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Stand-in for the byte transceiver: logs each requested byte and holds
   // tx_busy for a few cycles so the DUT sees a rise followed by a fall.
   initial begin
      txBusy = 1'b0;
      forever begin
         @(posedge clock);
         if (txSend === 1'b1) begin
            txLog.push_back(txData);
            #1 txBusy = 1'b1;
            repeat (4) @(posedge clock);
            #1 txBusy = 1'b0;
         end
      end
   end

   // Tally completion and failure pulses so reset and pending tests can
   // confirm exactly how many were produced.
   always @(posedge clock) begin
      if (ledDone === 1'b1) doneCount++;
      if (ledFail === 1'b1) failCount++;
   end

   // Safety net in case something upstream stalls forever.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One received byte: rx_valid for exactly one cycle, leaving the bench
   // just after the edge where the registered response is visible.
   task automatic applyStimulus(input logic [7:0] b);
      rxData  = b;
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
   endtask

   task automatic pulseLedReq(input logic [2:0] v);
      ledVal = v;
      ledReq = 1'b1;
      tick();
      ledReq = 1'b0;
   endtask

   // Wait until the n-th transmitted byte is logged, then let the busy
   // window finish so the DUT is listening for the reply.
   task automatic waitTx(input int n);
      int k = 0;
      while (txLog.size() < n && k < 200) begin
         tick();
         k++;
      end
      checkOutput("txIssued", 32'(txLog.size() >= n), 1);
      repeat (7) tick();
   endtask

   // Main directed sequence.
   initial begin
      int waited;
      int doneBase;
      int failBase;
      logic seenFail;

      resetN = 1'b0; rxData = 8'h00; rxValid = 1'b0;
      ledReq = 1'b0; ledVal = 3'b000;
      repeat (3) tick();
      resetN = 1'b1;
      tick();

      checkOutput("rstWasd", 32'(wasd), 0);
      checkOutput("rstArrows", 32'(arrows), 0);
      checkOutput("rstTxData", 32'(txData), 0);
      checkOutput("rstTxSend", 32'(txSend), 0);
      checkOutput("rstLedBusy", 32'(ledBusy), 0);
      checkOutput("rstKeyEvent", 32'(keyEvent), 0);

      applyStimulus(8'h1D);
      checkOutput("wMakeEvent", 32'(keyEvent), 1);
      checkOutput("wMakeHeld", 32'(wasd), 32'h1);
      checkOutput("wMakeBreak", 32'(keyBreak), 0);
      tick();
      checkOutput("eventOneCycle", 32'(keyEvent), 0);
      applyStimulus(8'hF0);
      checkOutput("prefixNoEvent", 32'(keyEvent), 0);
      checkOutput("prefixStillHeld", 32'(wasd), 32'h1);
      applyStimulus(8'h1D);
      checkOutput("wBreakEvent", 32'(keyEvent), 1);
      checkOutput("wBreakFlag", 32'(keyBreak), 1);
      checkOutput("wBreakCode", 32'(keyCode), 32'h1D);
      checkOutput("wReleased", 32'(wasd), 0);

      applyStimulus(8'hE0);
      applyStimulus(8'h75);
      checkOutput("upMake", 32'(arrows), 32'h1);
      checkOutput("upMakeExt", 32'(keyExt), 1);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h75);
      checkOutput("upBreak", 32'(arrows), 0);
      checkOutput("upBreakExt", 32'(keyExt), 1);
      checkOutput("upBreakFlag", 32'(keyBreak), 1);
      applyStimulus(8'h75);
      checkOutput("plain75Event", 32'(keyEvent), 1);
      checkOutput("plain75Ext", 32'(keyExt), 0);
      checkOutput("plain75Arrows", 32'(arrows), 0);

      applyStimulus(8'hF0);
      applyStimulus(8'h00);
      checkOutput("overrunErr", 32'(protoErr), 1);
      checkOutput("overrunNoEvent", 32'(keyEvent), 0);
      applyStimulus(8'h5A);
      checkOutput("enterMake", 32'(enter), 1);
      checkOutput("enterNotBreak", 32'(keyBreak), 0);

      applyStimulus(8'hFA);
      checkOutput("idleAckNoEvent", 32'(keyEvent), 0);
      checkOutput("idleAckNoErr", 32'(protoErr), 0);

      // LED write 3'b101 with a key press landing while the ED is unacked.
      txLog.delete();
      doneBase = doneCount;
      pulseLedReq(3'b101);
      checkOutput("busyRises", 32'(ledBusy), 1);
      waitTx(1);
      checkOutput("firstByteED", 32'(txLog[0]), 32'hED);
      applyStimulus(8'h29);
      checkOutput("spaceDuringCmd", 32'(space), 1);
      checkOutput("spaceEvent", 32'(keyEvent), 1);
      checkOutput("cmdStillBusy", 32'(ledBusy), 1);
      repeat (3) tick();
      checkOutput("noExtraTx", 32'(txLog.size()), 1);
      applyStimulus(8'hFA);
      checkOutput("busyAfterAck1", 32'(ledBusy), 1);
      waitTx(2);
      checkOutput("argByte05", 32'(txLog[1]), 32'h05);
      checkOutput("busyBeforeAck2", 32'(ledBusy), 1);
      applyStimulus(8'hFA);
      checkOutput("donePulse", 32'(ledDone), 1);
      checkOutput("busyDropsWithDone", 32'(ledBusy), 0);
      tick();
      checkOutput("doneOneCycle", 32'(ledDone), 0);
      checkOutput("doneCountOne", 32'(doneCount - doneBase), 1);

      // Resend exhaustion: FE four times to the ED byte.
      txLog.delete();
      pulseLedReq(3'b001);
      for (int i = 0; i < 4; i++) begin
         waitTx(i + 1);
         applyStimulus(8'hFE);
      end
      checkOutput("retryFail", 32'(ledFail), 1);
      checkOutput("retryBusyLow", 32'(ledBusy), 0);
      checkOutput("retrySends", 32'(txLog.size()), 4);
      for (int i = 0; i < 4; i++)
         checkOutput("retryByteED", 32'(txLog[i]), 32'hED);

      // Silence after the ED byte must time out.
      txLog.delete();
      tick();
      pulseLedReq(3'b010);
      waitTx(1);
      waited = 0;
      seenFail = 1'b0;
      while (!seenFail && waited < 200) begin
         tick();
         waited++;
         if (ledFail === 1'b1) seenFail = 1'b1;
      end
      checkOutput("timeoutFail", 32'(seenFail), 1);
      checkOutput("timeoutWindow", 32'(waited >= 30 && waited <= 42), 1);

      // Requests while busy queue one deep; the last one (3'b110) wins.
      txLog.delete();
      tick();
      doneBase = doneCount;
      pulseLedReq(3'b010);
      pulseLedReq(3'b011);
      pulseLedReq(3'b110);
      waitTx(1);
      applyStimulus(8'hFA);
      waitTx(2);
      checkOutput("pendFirstArg", 32'(txLog[1]), 32'h02);
      applyStimulus(8'hFA);
      checkOutput("pendFirstDone", 32'(ledDone), 1);
      waitTx(3);
      checkOutput("pendSecondED", 32'(txLog[2]), 32'hED);
      applyStimulus(8'hFA);
      waitTx(4);
      checkOutput("pendSecondArg", 32'(txLog[3]), 32'h06);
      applyStimulus(8'hFA);
      checkOutput("pendSecondDone", 32'(ledDone), 1);
      repeat (20) tick();
      checkOutput("pendNoThird", 32'(txLog.size()), 4);
      checkOutput("pendDoneCount", 32'(doneCount - doneBase), 2);

      // Reset in the middle of a command: silent abandon.
      txLog.delete();
      pulseLedReq(3'b111);
      waitTx(1);
      doneBase = doneCount;
      failBase = failCount;
      resetN = 1'b0;
      #1;
      checkOutput("rstMidBusy", 32'(ledBusy), 0);
      checkOutput("rstMidSpace", 32'(space), 0);
      repeat (3) tick();
      resetN = 1'b1;
      repeat (ACK_TO + 20) tick();
      checkOutput("rstNoDone", 32'(doneCount - doneBase), 0);
      checkOutput("rstNoFail", 32'(failCount - failBase), 0);
      checkOutput("rstStaysIdle", 32'(ledBusy), 0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
